alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational-result ALU between two requesters, for example the execute stage and a multiply/divide helper.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Round-robin grant; one operation in flight at a time.
- Sits between the requesters and the ALU A/B/ALUOperation/ALUResult/Zero pins.

Parameters:
- W, 32, operand/result width.
- OPW, 4, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accept.
- req_a  in  2*W  operand A; requester i in bits [i*W +: W].
- req_b  in  2*W  operand B, same packing.
- req_op  in  2*OPW  operation code, packed per requester.
- resp_valid  out  2  response valid for requester i.
- resp_ready  in  2  response accept from requester i.
- resp_result  out  W  shared result bus; qualified by resp_valid.
- resp_zero  out  1  shared Zero flag; qualified by resp_valid.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_op  out  OPW  to ALU ALUOperation.
- alu_result  in  W  from ALU ALUResult.
- alu_zero  in  1  from ALU Zero.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, last_grant=1 (requester 0 wins first tie). All output registers cleared: alu_a/alu_b/alu_op, resp_result, resp_zero, resp_valid=0. req_ready=0, busy=0.
- Reset mid-operation: the in-flight op is discarded and no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with req_valid; if both are valid, the one != last_grant.
  - req_ready[grant]=1 combinationally in IDLE only; the other bit is 0.
  - On handshake: latch a/b/op into alu_a/alu_b/alu_op registers, store grant id, go to EXEC.
  - No valid: stay in IDLE; ALU outputs hold their last values.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable from the registers.
  - At the end of the cycle, capture alu_result→resp_result and alu_zero→resp_zero.
  - Set resp_valid[grant]; go to RESP.
- RESP:
  - resp_valid[grant] and resp_result/resp_zero are held stable until resp_ready[grant]=1.
  - On that edge: clear resp_valid, last_grant=grant, go to IDLE.
  - resp_ready on the non-granted bit is ignored.
- Latency: handshake in cycle N → resp_valid in cycle N+2. Minimum 3 cycles per op; no back-to-back acceptance.
- A requester may drop req_valid before being granted; there is no penalty.
- The arbiter ignores requests while busy. A requester waiting on its own response cannot be re-granted until IDLE.
- req_ready is never asserted outside IDLE.
- Widths: pass-through only; no arithmetic inside the block.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output ports op_cnt0 and op_cnt1, 16 bits each.
  - Each counts completed responses (resp handshakes) for its requester; wraps at 0xFFFF→0.
  - Cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - OPW default.
  - Named ALU op-code constants shared with the ALU.
- Sub-module rr_arb2: combinational round-robin picker.
  - Inputs: valid[1:0], last_grant.
  - Outputs: grant_id, grant_any.

Test Plan:
- Bench ALU stub (result=A+B, zero=(result==0)):
  - req0 a=21, b=11, op=9 → req_ready[0] in the same cycle.
  - alu_op=9 in EXEC.
  - resp_valid[0] two cycles later; resp_result=32, resp_zero=0.
- Both valid at once after reset, req1 a=5, b=-5:
  - req0 is served first.
  - req1 is served next with resp_result=0, resp_zero=1.
  - Then with both valid again, req0 wins (alternation).
- resp_ready[0] held low for 4 cycles:
  - resp_valid[0] and resp_result stay stable.
  - req_ready stays 0 even with req1 valid.
- reset pulse asserted during EXEC:
  - All outputs go to 0 immediately (asynchronous); no response is issued.
  - Next request from req0 is served normally.
- req1 valid for 1 cycle while busy, then dropped → never granted, no response.
- With ALU_ARB_STATS_EN, after 3 req0 and 2 req1 completions → op_cnt0=3, op_cnt1=2.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the ALU arbiter.
//   - state encoding for the arbiter FSM
//   - default ALU operation-code width
//   - named ALU operation codes shared with the ALU itself
//   - small helper to turn a requester id into a one-hot pair
`timescale 1ns/1ps
package alu_arb_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_RESP = ST_RESP
  } arb_state_t;

  // ALU operation codes (MIPS-style ALU control encoding)
  localparam logic [ALU_OPW-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_NOR = 4'd12;

  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   valid      in  2  request valid per requester
//   last_grant in  1  requester served most recently
//   grant_id   out 1  chosen requester (meaningful when grant_any)
//   grant_any  out 1  at least one requester is valid
// On a tie the requester that was not served last wins.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_any
);

  always_comb begin
    grant_any = |valid;
    grant_id  = 1'b0;
    if (&valid)
      grant_id = ~last_grant;
    else if (valid[1])
      grant_id = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation in flight; round-robin grant; valid/ready on both the
// request and the response side.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     per-requester request handshake (bit i = req i)
//   req_a/req_b/req_op      packed operands/opcode, requester i at [i*W +: W]
//   resp_valid/resp_ready   per-requester response handshake
//   resp_result/resp_zero   shared response bus, qualified by resp_valid
//   alu_a/alu_b/alu_op      registered drive of the ALU inputs
//   alu_result/alu_zero     ALU outputs, sampled at the end of EXEC
//   busy                    high while in EXEC or RESP
//
// Optional feature (macro ALU_ARB_STATS_EN): adds op_cnt0/op_cnt1, 16-bit
// wrapping counts of completed response handshakes per requester.
//
// Timing: handshake in cycle N, EXEC in N+1, resp_valid from N+2 until the
// granted requester takes it. No new request is accepted outside IDLE.
`timescale 1ns/1ps
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = ALU_OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  input  logic [2*OPW-1:0] req_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [W-1:0]     resp_result,
  output logic             resp_zero,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_zero,
  output logic             busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      op_cnt0,
  output logic [15:0]      op_cnt1
`endif
);

  // per-requester views of the packed request buses
  logic [1:0][W-1:0]   a_v;
  logic [1:0][W-1:0]   b_v;
  logic [1:0][OPW-1:0] op_v;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign op_v = req_op;

  arb_state_t state;
  logic       last_grant;
  logic       gnt_q;       // requester owning the in-flight op
  logic       gnt_id;
  logic       gnt_any;
  logic       take;        // request handshake this cycle
  logic       done;        // response handshake this cycle

  rr_arb2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant_id   (gnt_id),
    .grant_any  (gnt_any)
  );

  // req_ready only ever rises in IDLE, and only for a valid requester, so
  // a raised ready bit is itself the handshake.
  assign take      = (state == S_IDLE) && gnt_any;
  assign req_ready = take ? onehot2(gnt_id) : 2'b00;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_RESP) && resp_ready[gnt_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;       // requester 0 wins the first tie
      gnt_q       <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_valid  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          // ALU input registers hold their last values while idle
          if (take) begin
            alu_a  <= a_v[gnt_id];
            alu_b  <= b_v[gnt_id];
            alu_op <= op_v[gnt_id];
            gnt_q  <= gnt_id;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU has had a full cycle on stable registered inputs
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_valid  <= onehot2(gnt_q);
          state       <= S_RESP;
        end
        S_RESP: begin
          // only the owner's resp_ready matters; result held until taken
          if (resp_ready[gnt_q]) begin
            resp_valid <= 2'b00;
            last_grant <= gnt_q;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_cnt0 <= '0;
      op_cnt1 <= '0;
    end else if (done) begin
      if (gnt_q) op_cnt1 <= op_cnt1 + 16'd1;
      else       op_cnt0 <= op_cnt0 + 16'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int W   = 32;
  localparam int OPW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*W-1:0]   req_a;
  logic [2*W-1:0]   req_b;
  logic [2*OPW-1:0] req_op;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [W-1:0]     resp_result;
  logic             resp_zero;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [OPW-1:0]   alu_op;
  logic [W-1:0]     alu_result;
  logic             alu_zero;
  logic             busy;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      op_cnt0;
  logic [15:0]      op_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU stub: result = A + B, zero = (result == 0)
  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == '0);

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_cnt0     (op_cnt0),
    .op_cnt1     (op_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OPW-1:0] op);
    req_a[i*W +: W]       = a;
    req_b[i*W +: W]       = b;
    req_op[i*OPW +: OPW]  = op;
    req_valid[i]          = 1'b1;
  endtask

  // Called in an IDLE cycle just after a rising edge with inputs applied.
  // Returns just after the edge that completes the response handshake.
  task automatic do_op(input int who, input logic [W-1:0] a, input logic [OPW-1:0] op,
                       input logic [W-1:0] res, input logic z);
    logic [1:0] oh;
    oh = (who == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("grant", req_ready, oh);
    @(posedge clk); #1;
    req_valid[who] = 1'b0;
    @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_a", alu_a, a);
    chk("exec_op", alu_op, op);
    chk("exec_rv", resp_valid, 0);
    chk("exec_rdy", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_valid", resp_valid, oh);
    chk("resp_result", resp_result, res);
    chk("resp_zero", resp_zero, z);
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    chk("resp_clear", resp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  // reference-model state for the random phase
  bit              m_busy, m_offer, m_last, m_owner;
  logic [W-1:0]    m_a, m_b, m_res;
  logic [OPW-1:0]  m_op;
  int              m_cnt[2];
  bit [1:0]        pend;
  logic [W-1:0]    ra[2], rb[2];
  logic [OPW-1:0]  rop[2];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    do_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_zero", resp_zero, 0);

    // ---- single request from req0
    set_req(0, 32'd21, 32'd11, 4'd9);
    do_op(0, 32'd21, 4'd9, 32'd32, 1'b0);

    // ---- both valid after reset: req0, then req1, then req0 again
    do_reset();
    set_req(0, 32'd21, 32'd11, 4'd9);
    set_req(1, 32'd5, -32'sd5, 4'd2);
    do_op(0, 32'd21, 4'd9, 32'd32, 1'b0);
    do_op(1, 32'd5, 4'd2, 32'd0, 1'b1);
    set_req(0, 32'd3, 32'd4, 4'd1);
    set_req(1, 32'd10, 32'd20, 4'd3);
    do_op(0, 32'd3, 4'd1, 32'd7, 1'b0);
    do_op(1, 32'd10, 4'd3, 32'd30, 1'b0);

    // ---- response stall: resp_ready[0] low 4 cycles, req1 waiting
    set_req(0, 32'd40, 32'd2, 4'd5);
    @(negedge clk);
    chk("stall_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, 32'd9, 32'd9, 4'd4);
    resp_ready = 2'b10;               // non-owner ready must be ignored
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_rv", resp_valid, 2'b01);
      chk("stall_res", resp_result, 32'd42);
      chk("stall_rdy", req_ready, 0);
      chk("stall_busy", busy, 1);
      @(posedge clk); #1;
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    chk("stall_clear", resp_valid, 0);
    do_op(1, 32'd9, 4'd4, 32'd18, 1'b0);

    // ---- reset pulse during EXEC
    set_req(0, 32'd7, 32'd8, 4'd6);
    @(negedge clk);
    chk("rx_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1 reset = 1'b1;
    #1;
    chk("rx_rv", resp_valid, 0);
    chk("rx_busy", busy, 0);
    chk("rx_alu_a", alu_a, 0);
    chk("rx_alu_b", alu_b, 0);
    chk("rx_alu_op", alu_op, 0);
    chk("rx_result", resp_result, 0);
    chk("rx_rdy", req_ready, 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rx_noresp", resp_valid, 0);
    end
    @(posedge clk); #1;
    set_req(0, 32'd100, 32'd23, 4'd2);
    do_op(0, 32'd100, 4'd2, 32'd123, 1'b0);

    // ---- req1 pulses valid only while busy, then drops: never granted
    set_req(0, 32'd1, 32'd1, 4'd0);
    @(negedge clk);
    chk("drop_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("drop_rv", resp_valid, 2'b01);
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drop_rdy", req_ready, 0);
      chk("drop_rv2", resp_valid, 0);
      chk("drop_busy", busy, 0);
      @(posedge clk); #1;
    end
    resp_ready = 2'b00;

    // ---- completion counters
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(0, k, 32'd1, 4'd2);
      do_op(0, k, 4'd2, k + 1, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      set_req(1, 32'd50, k, 4'd2);
      do_op(1, 32'd50, 4'd2, 50 + k, 1'b0);
    end
`ifdef ALU_ARB_STATS_EN
    chk("cnt0", op_cnt0, 3);
    chk("cnt1", op_cnt1, 2);
`endif

    // ---- randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_offer = 0; m_last = 1; m_owner = 0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    pend = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      bit        w;
      logic [1:0] exp_rdy, exp_rv;
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && $urandom_range(0, 7) == 0)
          pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          ra[i]  = $urandom;
          rb[i]  = ($urandom_range(0, 3) == 0) ? -ra[i] : $urandom;
          rop[i] = 4'($urandom);
        end
      end
      req_valid  = pend;
      req_a      = {ra[1], ra[0]};
      req_b      = {rb[1], rb[0]};
      req_op     = {rop[1], rop[0]};
      resp_ready = 2'($urandom);
      @(negedge clk);
      // winner: the only valid one, or on a tie the one not served last
      w = (pend == 2'b11) ? !m_last : pend[1];
      exp_rdy = (!m_busy && pend != 0) ? (w ? 2'b10 : 2'b01) : 2'b00;
      exp_rv  = (m_busy && m_offer) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_rdy", req_ready, exp_rdy);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_rv", resp_valid, exp_rv);
      chk("rnd_alu_a", alu_a, m_a);
      chk("rnd_alu_b", alu_b, m_b);
      chk("rnd_alu_op", alu_op, m_op);
      if (exp_rv != 0) begin
        chk("rnd_res", resp_result, m_res);
        chk("rnd_zero", resp_zero, m_res == 0);
      end
      if (!m_busy && pend != 0) begin
        m_busy = 1; m_offer = 0; m_owner = w;
        m_a = ra[w]; m_b = rb[w]; m_op = rop[w];
        m_res = ra[w] + rb[w];
        pend[w] = 1'b0;
      end else if (m_busy && !m_offer) begin
        m_offer = 1;
      end else if (m_busy && resp_ready[m_owner]) begin
        m_busy = 0; m_offer = 0; m_last = m_owner;
        m_cnt[m_owner]++;
      end
      @(posedge clk); #1;
    end
`ifdef ALU_ARB_STATS_EN
    chk("rnd_cnt0", op_cnt0, 16'(m_cnt[0]));
    chk("rnd_cnt1", op_cnt1, 16'(m_cnt[1]));
`endif
    chk("rnd_progress", (m_cnt[0] > 0) && (m_cnt[1] > 0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
